// File: rtl/sketch_skyline_pkg.sv
// Shared widths, sizes and FSM encoding for the skyline-outline engine.
package sketch_skyline_pkg;

  localparam int DATA_WIDTH    = 6;
  localparam int NUM_BLD       = 8;
  localparam int WORDS_PER_IMG = 3 * NUM_BLD;
  localparam int MAX_OUT       = 32;
  localparam int MAX_KP        = MAX_OUT / 2;
  localparam int WCNT_W        = $clog2(WORDS_PER_IMG);
  localparam int KCNT_W        = $clog2(MAX_KP + 1);
  localparam int KIDX_W        = $clog2(MAX_KP);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_OUT
  } state_t;

  function automatic word_t max_word(input word_t a, input word_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sketch_max_height.sv
// Combinational skyline height at one x: per-building coverage test feeding
// a three-level maximum tree.
module sketch_max_height
  import sketch_skyline_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]              x,
  input  logic [NUM_BLD-1:0][DATA_WIDTH-1:0] bld_left,
  input  logic [NUM_BLD-1:0][DATA_WIDTH-1:0] bld_height,
  input  logic [NUM_BLD-1:0][DATA_WIDTH-1:0] bld_right,
  output logic [DATA_WIDTH-1:0]              max_h
);

  word_t cand [NUM_BLD];
  word_t lvl1 [NUM_BLD/2];
  word_t lvl2 [NUM_BLD/4];

  // Half-open span [L, R): an empty or inverted span never covers anything.
  always_comb begin
    for (int i = 0; i < NUM_BLD; i++) begin
      cand[i] = ((x >= bld_left[i]) && (x < bld_right[i])) ? bld_height[i] : '0;
    end
    for (int i = 0; i < NUM_BLD/2; i++) begin
      lvl1[i] = max_word(cand[2*i], cand[2*i+1]);
    end
    for (int i = 0; i < NUM_BLD/4; i++) begin
      lvl2[i] = max_word(lvl1[2*i], lvl1[2*i+1]);
    end
    max_h = max_word(lvl2[0], lvl2[1]);
  end

endmodule

// File: rtl/sketch_skyline.sv
// Streaming skyline engine: loads 8 buildings, sweeps x = 0..63 one per cycle
// collecting key points, then drains them as a contiguous (x, height) burst.
module sketch_skyline
  import sketch_skyline_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA
);

  localparam word_t X_LAST = '1;

  state_t              state, state_nxt;
  word_t               words [WORDS_PER_IMG];
  logic [WCNT_W-1:0]   word_cnt;
  word_t               sweep_x, prev_h, cur_h;
  word_t               kp_x [MAX_KP];
  word_t               kp_h [MAX_KP];
  logic [KCNT_W-1:0]   kp_cnt;
  logic [KIDX_W-1:0]   out_idx;
  logic                out_phase;

  logic [NUM_BLD-1:0][DATA_WIDTH-1:0] bld_left, bld_height, bld_right;

  logic load_word, last_load, key_found, last_out;

  assign load_word = IN_VALID && ((state == ST_IDLE) || (state == ST_LOAD));
  assign last_load = IN_VALID && (state == ST_LOAD) &&
                     (word_cnt == WCNT_W'(WORDS_PER_IMG - 1));
  assign key_found = (state == ST_SWEEP) && (cur_h != prev_h);
  assign last_out  = out_phase && ({1'b0, out_idx} == (kp_cnt - KCNT_W'(1)));

  always_comb begin
    for (int i = 0; i < NUM_BLD; i++) begin
      bld_left[i]   = words[3*i];
      bld_height[i] = words[3*i+1];
      bld_right[i]  = words[3*i+2];
    end
  end

  sketch_max_height u_max_height (
    .x          (sweep_x),
    .bld_left   (bld_left),
    .bld_height (bld_height),
    .bld_right  (bld_right),
    .max_h      (cur_h)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The final x may itself produce a key point, so it counts toward leaving SWEEP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (IN_VALID) state_nxt = ST_LOAD;
      ST_LOAD:  if (last_load) state_nxt = ST_SWEEP;
      ST_SWEEP: if (sweep_x == X_LAST)
                  state_nxt = ((kp_cnt != '0) || key_found) ? ST_OUT : ST_IDLE;
      ST_OUT:   if (last_out) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_cnt <= '0;
      for (int i = 0; i < WORDS_PER_IMG; i++) words[i] <= '0;
    end else if (load_word) begin
      words[word_cnt] <= IN_DATA;
      word_cnt        <= last_load ? '0 : word_cnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sweep_x   <= '0;
      prev_h    <= '0;
      kp_cnt    <= '0;
      out_idx   <= '0;
      out_phase <= 1'b0;
      for (int i = 0; i < MAX_KP; i++) begin
        kp_x[i] <= '0;
        kp_h[i] <= '0;
      end
    end else if (last_load) begin
      sweep_x   <= '0;
      prev_h    <= '0;
      kp_cnt    <= '0;
      out_idx   <= '0;
      out_phase <= 1'b0;
    end else if (state == ST_SWEEP) begin
      prev_h <= cur_h;
      if (sweep_x != X_LAST) sweep_x <= sweep_x + DATA_WIDTH'(1);
      if (key_found) begin
        kp_x[kp_cnt[KIDX_W-1:0]] <= sweep_x;
        kp_h[kp_cnt[KIDX_W-1:0]] <= cur_h;
        kp_cnt                   <= kp_cnt + KCNT_W'(1);
      end
    end else if (state == ST_OUT) begin
      out_phase <= ~out_phase;
      if (out_phase) out_idx <= out_idx + KIDX_W'(1);
    end
  end

  // Outputs decode straight from state so reset silences them immediately.
  always_comb begin
    OUT_VALID = (state == ST_OUT);
    OUT_DATA  = '0;
    if (OUT_VALID) OUT_DATA = out_phase ? kp_h[out_idx] : kp_x[out_idx];
  end

endmodule

// File: tb/tb_sketch_skyline.sv
// Self-checking bench for sketch_skyline: directed and random images compared
// against a per-x skyline model, plus burst shape, latency and reset checks.
module tb_sketch_skyline;
  import sketch_skyline_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  IN_VALID;
  logic [DATA_WIDTH-1:0] IN_DATA;
  logic                  OUT_VALID;
  logic [DATA_WIDTH-1:0] OUT_DATA;

  int  testCount = 0;
  int  failCount = 0;
  int  imgL [NUM_BLD];
  int  imgH [NUM_BLD];
  int  imgR [NUM_BLD];
  int  expQ [$];
  int  gotQ [$];
  int  burstCount = 0;
  int  zeroViol = 0;
  bit  sawOut = 1'b0;
  bit  prevValid = 1'b0;
  time lastInTime = 0;
  time firstOutTime = 0;

  sketch_skyline dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA)
  );

  always #5 CLK = ~CLK;

  // Collects every output word and notes burst starts and non-zero idle data.
  always @(negedge CLK) begin
    if (OUT_VALID) begin
      gotQ.push_back(int'(OUT_DATA));
      if (!prevValid) begin
        burstCount++;
        if (!sawOut) begin
          sawOut = 1'b1;
          firstOutTime = $time;
        end
      end
    end else if (OUT_DATA !== '0) begin
      zeroViol++;
    end
    prevValid = OUT_VALID;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < NUM_BLD; i++) begin
      imgL[i] = 0;
      imgH[i] = 0;
      imgR[i] = 0;
    end
  endtask

  task automatic setBld(input int i, input int l, input int h, input int r);
    imgL[i] = l;
    imgH[i] = h;
    imgR[i] = r;
  endtask

  // h(x) = tallest building covering x; a key point wherever h changes.
  task automatic computeModel();
    int prev, h;
    expQ.delete();
    prev = 0;
    for (int x = 0; x < 64; x++) begin
      h = 0;
      for (int i = 0; i < NUM_BLD; i++)
        if (imgH[i] > 0 && x >= imgL[i] && x < imgR[i] && imgH[i] > h) h = imgH[i];
      if (h != prev) begin
        expQ.push_back(x);
        expQ.push_back(h);
      end
      prev = h;
    end
  endtask

  task automatic applyStimulus();
    computeModel();
    gotQ.delete();
    burstCount = 0;
    zeroViol = 0;
    sawOut = 1'b0;
    for (int i = 0; i < NUM_BLD; i++) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge CLK);
        IN_VALID = 1'b1;
        IN_DATA  = (w == 0) ? DATA_WIDTH'(imgL[i]) :
                   (w == 1) ? DATA_WIDTH'(imgH[i]) : DATA_WIDTH'(imgR[i]);
        lastInTime = $time;
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA  = '0;
  endtask

  task automatic waitBurstEnd();
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (gotQ.size() > 0 && !OUT_VALID) break;
      if (expQ.size() == 0 && k >= 70) break;
    end
  endtask

  task automatic verifyImage(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      if (i < gotQ.size()) checkOutput($sformatf("%s_w%0d", tag, i), gotQ[i], expQ[i]);
    checkOutput({tag, "_bursts"}, burstCount, (expQ.size() > 0) ? 1 : 0);
    if (expQ.size() > 0 && sawOut)
      checkOutput({tag, "_latency"}, int'((firstOutTime - lastInTime) <= 1000), 1);
    checkOutput({tag, "_idle_zero"}, zeroViol, 0);
  endtask

  task automatic runImage(input string tag);
    applyStimulus();
    waitBurstEnd();
    verifyImage(tag);
  endtask

  initial begin
    RESET    = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_valid", int'(OUT_VALID), 0);
    checkOutput("reset_data", int'(OUT_DATA), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    clearImage();
    for (int i = 0; i < NUM_BLD; i++) setBld(i, 2, 5, 6);
    runImage("all_same");

    clearImage();
    setBld(0, 1, 10, 5);
    setBld(1, 3, 6, 8);
    runImage("overlap");

    clearImage();
    setBld(0, 1, 5, 3);
    setBld(1, 3, 5, 6);
    runImage("touch_equal");

    clearImage();
    setBld(0, 1, 5, 3);
    setBld(1, 3, 8, 6);
    runImage("touch_diff");

    clearImage();
    setBld(0, 1, 4, 2);
    setBld(1, 5, 4, 7);
    runImage("gap");

    clearImage();
    setBld(0, 0, 63, 63);
    runImage("edge");

    // Three images back to back, the last one contributing nothing.
    clearImage();
    setBld(3, 10, 20, 30);
    setBld(5, 25, 40, 35);
    runImage("b2b_a");
    clearImage();
    setBld(0, 50, 7, 60);
    setBld(7, 40, 9, 55);
    setBld(2, 12, 33, 12);
    runImage("b2b_b");
    clearImage();
    setBld(1, 9, 0, 20);
    setBld(4, 30, 15, 20);
    runImage("b2b_empty");

    // Stray IN_VALID while sweeping must not disturb the result.
    clearImage();
    setBld(2, 4, 11, 19);
    setBld(6, 15, 22, 40);
    applyStimulus();
    repeat (4) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1;
      IN_DATA  = DATA_WIDTH'($urandom_range(63, 0));
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    waitBurstEnd();
    verifyImage("ignore_in");

    // Reset pulsed in the middle of an output burst.
    clearImage();
    setBld(0, 3, 12, 9);
    setBld(1, 20, 30, 44);
    setBld(2, 50, 5, 62);
    applyStimulus();
    for (int k = 0; k < 150; k++) begin
      @(negedge CLK);
      if (gotQ.size() >= 3) break;
    end
    checkOutput("rst_burst_started", int'(gotQ.size() >= 3), 1);
    RESET = 1'b1;
    #1;
    checkOutput("rst_mid_valid", int'(OUT_VALID), 0);
    checkOutput("rst_mid_data", int'(OUT_DATA), 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    clearImage();
    setBld(0, 7, 13, 21);
    setBld(5, 14, 13, 30);
    runImage("after_rst");

    for (int n = 0; n < 6; n++) begin
      clearImage();
      for (int i = 0; i < NUM_BLD; i++) begin
        setBld(i, int'($urandom_range(63, 0)),
               ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(63, 1)),
               int'($urandom_range(63, 0)));
      end
      runImage($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
